// File: rtl/fb_arbiter_if.sv
// fb_arbiter_if: scan-out read, two pixel-writer, video-memory and statistics signals of the framebuffer arbiter.
//   slave  modport: the arbiter (takes requests and mem_rdata, drives grants, flags, mem_* commands, read returns, counters)
//   master modport: the surrounding system (vga_ctrl, painter, UART loader, memory array)
interface fb_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 24
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr0_req, wr1_req;
    logic [ADDR_W-1:0] wr0_addr, wr1_addr;
    logic [DATA_W-1:0] wr0_data, wr1_data;
    logic              wr0_gnt, wr1_gnt;
    logic              wr0_starve, wr1_starve;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stats_clr;
    logic [15:0]       stall_cnt0, stall_cnt1;

    modport slave (
        input  rd_req, rd_addr, wr0_req, wr1_req, wr0_addr, wr1_addr, wr0_data, wr1_data,
        input  mem_rdata, stats_clr,
        output rd_data, rd_valid, wr0_gnt, wr1_gnt, wr0_starve, wr1_starve,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_cnt0, stall_cnt1
    );

    modport master (
        output rd_req, rd_addr, wr0_req, wr1_req, wr0_addr, wr1_addr, wr0_data, wr1_data,
        output mem_rdata, stats_clr,
        input  rd_data, rd_valid, wr0_gnt, wr1_gnt, wr0_starve, wr1_starve,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_cnt0, stall_cnt1
    );
endinterface

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer arbiter; scan-out reads have absolute priority, the two writers share the rest round-robin.
//   clk    : system clock
//   resetn : synchronous active-low reset
//   bus    : fb_arbiter_if.slave (read path, wr0/wr1 request-grant, mem_* command port, stall statistics)
// Optional feature: define FB_ARB_STATS_EN to build the saturating per-writer stall counters; otherwise they read 0.
module fb_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 24,
    parameter int STARVE_LIM = 1023
) (
    input  logic         clk,
    input  logic         resetn,
    fb_arbiter_if.slave  bus
);
    localparam logic [9:0] lim = 10'(STARVE_LIM);

    logic [1:0] req, gnt, waiting, starve, rd_pipe;
    logic       last;
    logic [9:0] wait_cnt [2];

    assign req = {bus.wr1_req, bus.wr0_req};
    // A tie goes to the writer that did not win last; grants are held off during reset.
    assign gnt = (!resetn || bus.rd_req) ? 2'b00 : (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
    assign waiting = req & ~gnt;

    assign bus.wr0_gnt    = gnt[0];
    assign bus.wr1_gnt    = gnt[1];
    assign bus.wr0_starve = starve[0];
    assign bus.wr1_starve = starve[1];
    assign bus.rd_data    = bus.mem_rdata;
    assign bus.rd_valid   = rd_pipe[1];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            last          <= 1'b1;
            rd_pipe       <= 2'b00;
        end else begin
            bus.mem_en    <= bus.rd_req | (|gnt);
            bus.mem_we    <= |gnt;
            bus.mem_addr  <= bus.rd_req ? bus.rd_addr : gnt[0] ? bus.wr0_addr : gnt[1] ? bus.wr1_addr : bus.mem_addr;
            bus.mem_wdata <= gnt[0] ? bus.wr0_data : gnt[1] ? bus.wr1_data : bus.mem_wdata;
            last          <= (|gnt) ? gnt[1] : last;
            rd_pipe       <= {rd_pipe[0], bus.rd_req};
        end
    end

    // The flag sets on the same edge the wait counter reaches the limit; the counter then parks there.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!resetn) begin
                wait_cnt[i] <= '0;
                starve[i]   <= 1'b0;
            end else begin
                wait_cnt[i] <= !waiting[i] ? '0 : (wait_cnt[i] == lim) ? wait_cnt[i] : wait_cnt[i] + 10'd1;
                starve[i]   <= gnt[i] ? 1'b0 : starve[i] | (waiting[i] && wait_cnt[i] == lim - 10'd1);
            end
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [15:0] stall [2];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!resetn || bus.stats_clr) stall[i] <= '0;
            else if (waiting[i] && stall[i] != 16'hFFFF) stall[i] <= stall[i] + 16'd1;
        end
    end

    assign bus.stall_cnt0 = stall[0];
    assign bus.stall_cnt1 = stall[1];
`else
    logic unused_stats_clr;

    assign unused_stats_clr = bus.stats_clr;
    assign bus.stall_cnt0   = '0;
    assign bus.stall_cnt1   = '0;
`endif
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: self-checking bench for fb_arbiter with a memory array, a behavioural reference model and directed sequences.
module tb_fb_arbiter;
    localparam int AW = 19;
    localparam int DW = 24;
    localparam int LIM = 1023;
`ifdef FB_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [AW-1:0] A0 = 19'h7FF10;
    localparam logic [AW-1:0] A1 = 19'h7FF20;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    function automatic logic [DW-1:0] pre(input logic [AW-1:0] a);
        return {5'h15, a} ^ 24'hC3A5F0;
    endfunction

    // video memory: one-cycle read latency, writes commit at the command edge
    logic [DW-1:0] fmem [logic [AW-1:0]];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) fmem[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata <= fmem.exists(bus.mem_addr) ? fmem[bus.mem_addr] : pre(bus.mem_addr);
        end
    end

    typedef struct { int due; logic [DW-1:0] d; } rd_t;
    typedef struct { bit rd; bit w0; bit w1; bit g0; bit g1; } vec_t;

    int errors = 0, checks = 0, cyc = 0;
    int m_last, d_w;
    int m_wait [2];
    bit m_starve [2];
    int m_stall [2];
    bit d_rd, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [DW-1:0] rmem [logic [AW-1:0]];
    rd_t rq [$];
    bit tbl_on = 1'b0, tbl_g0, tbl_g1;
    int v_cnt, v_first, v_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return rmem.exists(a) ? rmem[a] : pre(a);
    endfunction

    task automatic model_reset();
        m_last = 1;
        m_wait = '{0, 0};
        m_starve = '{0, 0};
        m_stall = '{0, 0};
        rq.delete();
        e_en = 1'b0;
        e_we = 1'b0;
        e_addr = '0;
        e_wdata = '0;
    endtask

    // decide this cycle's winner from the arbitration rules and compare every output
    task automatic look();
        bit exp_v;
        @(negedge clk);
        d_rd = resetn && bus.rd_req;
        if (!resetn || bus.rd_req) d_w = -1;
        else if (bus.wr0_req && bus.wr1_req) d_w = 1 - m_last;
        else if (bus.wr0_req) d_w = 0;
        else if (bus.wr1_req) d_w = 1;
        else d_w = -1;
        chk("wr0_gnt", bus.wr0_gnt, d_w == 0);
        chk("wr1_gnt", bus.wr1_gnt, d_w == 1);
        chk("mem_en", bus.mem_en, e_en);
        chk("mem_we", bus.mem_we, e_we);
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_wdata", bus.mem_wdata, e_wdata);
        chk("wr0_starve", bus.wr0_starve, m_starve[0]);
        chk("wr1_starve", bus.wr1_starve, m_starve[1]);
        chk("stall_cnt0", bus.stall_cnt0, m_stall[0]);
        chk("stall_cnt1", bus.stall_cnt1, m_stall[1]);
        exp_v = rq.size() > 0 && rq[0].due == cyc;
        chk("rd_valid", bus.rd_valid, exp_v);
        if (exp_v) begin
            chk("rd_data", bus.rd_data, rq[0].d);
            void'(rq.pop_front());
        end
        if (bus.rd_valid === 1'b1) begin
            if (v_first < 0) v_first = cyc;
            v_last = cyc;
            v_cnt++;
        end
        if (tbl_on) begin
            chk("tbl_g0", bus.wr0_gnt, tbl_g0);
            chk("tbl_g1", bus.wr1_gnt, tbl_g1);
        end
    endtask

    // advance the model across the coming edge, then step to just after it
    task automatic adv();
        bit wq [2];
        bit wt;
        wq[0] = bus.wr0_req;
        wq[1] = bus.wr1_req;
        if (!resetn) model_reset();
        else begin
            e_en = d_rd || d_w >= 0;
            e_we = d_w >= 0;
            if (d_rd) begin
                e_addr = bus.rd_addr;
                rq.push_back('{cyc + 2, ref_rd(bus.rd_addr)});
            end else if (d_w >= 0) begin
                e_addr = (d_w == 1) ? bus.wr1_addr : bus.wr0_addr;
                e_wdata = (d_w == 1) ? bus.wr1_data : bus.wr0_data;
                rmem[e_addr] = e_wdata;
                m_last = d_w;
            end
            for (int i = 0; i < 2; i++) begin
                wt = wq[i] && d_w != i;
                if (d_w == i) begin
                    m_wait[i] = 0;
                    m_starve[i] = 1'b0;
                end else if (wt) begin
                    m_wait[i]++;
                    if (m_wait[i] >= LIM) m_starve[i] = 1'b1;
                end else m_wait[i] = 0;
                if (STATS) begin
                    if (bus.stats_clr) m_stall[i] = 0;
                    else if (wt && m_stall[i] < 65535) m_stall[i]++;
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic tick();
        look();
        adv();
    endtask

    task automatic idle();
        bus.rd_req = 1'b0;
        bus.wr0_req = 1'b0;
        bus.wr1_req = 1'b0;
        bus.stats_clr = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [12];
        int start;
        logic [DW-1:0] old;
        tbl[0]  = '{1, 1, 1, 0, 0};
        tbl[1]  = '{0, 1, 1, 1, 0};
        tbl[2]  = '{0, 1, 1, 0, 1};
        tbl[3]  = '{0, 1, 1, 1, 0};
        tbl[4]  = '{0, 0, 1, 0, 1};
        tbl[5]  = '{0, 0, 1, 0, 1};
        tbl[6]  = '{0, 1, 1, 1, 0};
        tbl[7]  = '{0, 1, 0, 1, 0};
        tbl[8]  = '{0, 1, 1, 0, 1};
        tbl[9]  = '{0, 0, 0, 0, 0};
        tbl[10] = '{1, 1, 0, 0, 0};
        tbl[11] = '{0, 1, 1, 1, 0};
        idle();
        bus.rd_addr = '0;
        bus.wr0_addr = A0;
        bus.wr1_addr = A1;
        bus.wr0_data = 24'h111111;
        bus.wr1_data = 24'h222222;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        resetn = 1'b1;

        // reset state
        look();
        chk("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_rd_valid", bus.rd_valid, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_stall0", bus.stall_cnt0, 0);
        adv();

        // arbitration table
        foreach (tbl[k]) begin
            bus.rd_req = tbl[k].rd;
            bus.wr0_req = tbl[k].w0;
            bus.wr1_req = tbl[k].w1;
            bus.wr0_data = 24'(k * 24'h010101);
            bus.wr1_data = 24'(k * 24'h020202);
            tbl_on = 1'b1;
            tbl_g0 = tbl[k].g0;
            tbl_g1 = tbl[k].g1;
            tick();
        end
        tbl_on = 1'b0;
        idle();
        tick();

        // 640-pixel read burst
        v_cnt = 0;
        v_first = -1;
        v_last = -1;
        start = cyc;
        for (int i = 0; i < 640; i++) begin
            bus.rd_req = 1'b1;
            bus.rd_addr = AW'(i);
            tick();
        end
        idle();
        repeat (3) tick();
        chk("burst_latency", v_first - start, 2);
        chk("burst_count", v_cnt, 640);
        chk("burst_span", v_last - v_first + 1, 640);

        // continuous contention alternates, starting with wr0 after a wr1 grant
        bus.wr1_req = 1'b1;
        tick();
        bus.wr0_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.wr0_data = 24'(24'hA00000 + k);
            bus.wr1_data = 24'(24'hB00000 + k);
            look();
            chk("alt_g0", bus.wr0_gnt, k % 2 == 0);
            chk("alt_g1", bus.wr1_gnt, k % 2 == 1);
            if (k > 0) begin
                chk("alt_we", bus.mem_we, 1'b1);
                chk("alt_addr", bus.mem_addr, ((k - 1) % 2 == 0) ? A0 : A1);
            end
            adv();
        end
        idle();
        bus.stats_clr = 1'b1;
        tick();
        bus.stats_clr = 1'b0;

        // wr1 starved by 2000 cycles of scan-out
        bus.wr1_addr = 19'h7FF30;
        bus.wr1_data = 24'h5A5A5A;
        for (int k = 0; k < 2000; k++) begin
            bus.rd_req = 1'b1;
            bus.wr1_req = 1'b1;
            bus.rd_addr = AW'(k % 640);
            look();
            if (k == 1022) chk("starve_pre", bus.wr1_starve, 1'b0);
            if (k == 1023) chk("starve_set", bus.wr1_starve, 1'b1);
            adv();
        end
        bus.rd_req = 1'b0;
        look();
        chk("starve_gnt", bus.wr1_gnt, 1'b1);
        chk("starve_held", bus.wr1_starve, 1'b1);
        chk("stall1_2000", bus.stall_cnt1, STATS ? 2000 : 0);
        adv();
        bus.wr1_req = 1'b0;
        look();
        chk("starve_clr", bus.wr1_starve, 1'b0);
        adv();

        // same-address hazard around a wr0 write of 0xABCDEF to 0x00100
        old = ref_rd(19'h00100);
        bus.rd_req = 1'b1;
        bus.rd_addr = 19'h00100;
        bus.wr0_req = 1'b1;
        bus.wr0_addr = 19'h00100;
        bus.wr0_data = 24'hABCDEF;
        look();
        chk("haz_defer", bus.wr0_gnt, 1'b0);
        adv();
        bus.rd_req = 1'b0;
        look();
        chk("haz_wgnt", bus.wr0_gnt, 1'b1);
        adv();
        bus.wr0_req = 1'b0;
        bus.rd_req = 1'b1;
        look();
        chk("haz_old_v", bus.rd_valid, 1'b1);
        chk("haz_old", bus.rd_data, old);
        adv();
        bus.rd_req = 1'b0;
        tick();
        look();
        chk("haz_new_v", bus.rd_valid, 1'b1);
        chk("haz_new", bus.rd_data, 24'hABCDEF);
        adv();

        // reset pulse inside a read burst; last returns to 1
        bus.wr0_addr = A0;
        bus.wr0_req = 1'b1;
        tick();
        bus.wr0_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.rd_req = 1'b1;
            bus.rd_addr = AW'(200 + k);
            resetn = (k != 5);
            look();
            if (k == 6 || k == 7) chk("rst_pipe_v", bus.rd_valid, 1'b0);
            if (k == 8) chk("rst_restart_v", bus.rd_valid, 1'b1);
            adv();
        end
        resetn = 1'b1;
        bus.rd_req = 1'b0;
        bus.wr0_req = 1'b1;
        bus.wr1_req = 1'b1;
        look();
        chk("rst_tie_g0", bus.wr0_gnt, 1'b1);
        adv();
        idle();
        tick();

        // long stall: counter saturation and clear
        for (int k = 0; k < 70000; k++) begin
            bus.rd_req = 1'b1;
            bus.wr0_req = 1'b1;
            bus.rd_addr = AW'(k % 1024);
            tick();
        end
        look();
        chk("stall0_sat", bus.stall_cnt0, STATS ? 16'hFFFF : 16'h0);
        adv();
        bus.stats_clr = 1'b1;
        tick();
        bus.stats_clr = 1'b0;
        look();
        chk("stall0_clr", bus.stall_cnt0, 0);
        adv();
        idle();
        tick();

        // random traffic with hazards, drops, clears and occasional resets
        for (int n = 0; n < 3000; n++) begin
            bus.rd_req = $urandom_range(0, 1) == 1;
            bus.rd_addr = AW'(19'h300 + $urandom_range(0, 15));
            if (!bus.wr0_req || d_w == 0 || $urandom_range(0, 15) == 0) begin
                bus.wr0_req = $urandom_range(0, 3) != 0;
                bus.wr0_addr = AW'(19'h300 + $urandom_range(0, 15));
                bus.wr0_data = DW'($urandom);
            end
            if (!bus.wr1_req || d_w == 1 || $urandom_range(0, 15) == 0) begin
                bus.wr1_req = $urandom_range(0, 3) != 0;
                bus.wr1_addr = AW'(19'h300 + $urandom_range(0, 15));
                bus.wr1_data = DW'($urandom);
            end
            bus.stats_clr = $urandom_range(0, 63) == 0;
            resetn = $urandom_range(0, 399) != 0;
            tick();
        end
        resetn = 1'b1;
        idle();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
